multi_edge_detector: RTL and testbench

Parametrised, multi-channel successor to the single-channel Moore dual-edge detector.
- Each channel passes its asynchronous input through a configurable synchroniser, then a 4-state Moore FSM.
- The FSM emits one-cycle rise and/or fall pulses, gated by a per-channel mode.
- Sticky event flags with per-channel clear, and a last-edge-type register, let a CSR or interrupt block poll or acknowledge edges.
- Sits between raw GPIO/button inputs and interrupt or counter logic.

---
 rtl/edge_det_pkg.sv | 35 +++
 rtl/edge_det_channel.sv | 72 +++++++
 rtl/multi_edge_detector.sv | 41 ++++
 tb/tb_multi_edge_detector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared types and the per-channel state transition used by the multi-channel edge detector.
package edge_det_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    RISE = 2'b01,
    ONE  = 2'b10,
    FALL = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_SYNC = 4;

  // RISE/FALL are transient: a toggle while in them goes straight to the opposite edge.
  function automatic state_e next_state(input state_e cur, input logic s);
    state_e nxt;
    nxt = cur;
    case (cur)
      ZERO:    nxt = s ? RISE : ZERO;
      RISE:    nxt = s ? ONE  : FALL;
      ONE:     nxt = s ? ONE  : FALL;
      FALL:    nxt = s ? RISE : ZERO;
      default: nxt = ZERO;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One detector channel: synchroniser chain, Moore edge FSM, sticky event flag and last-edge type.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       signal_i,
  input  logic [1:0] mode_i,
  input  logic       clear_i,
  output logic       pulse_o,
  output logic       event_o,
  output logic       edge_type_o
);

  localparam state_e RST_STATE = INIT_LEVEL ? ONE : ZERO;

  logic   w_sync;
  logic   w_rise_en;
  logic   w_fall_en;
  logic   w_pulse;
  state_e r_state;
  logic   r_event;
  logic   r_type;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = signal_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_sync <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
          r_sync[0] <= signal_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end
      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Mode only gates the decoded output; the FSM keeps tracking the level while disabled.
  assign w_rise_en = mode_e'(mode_i) inside {MODE_RISE, MODE_BOTH};
  assign w_fall_en = mode_e'(mode_i) inside {MODE_FALL, MODE_BOTH};
  assign w_pulse   = ((r_state == RISE) && w_rise_en) || ((r_state == FALL) && w_fall_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RST_STATE;
      r_event <= 1'b0;
      r_type  <= 1'b0;
    end else begin
      r_state <= next_state(r_state, w_sync);
      if (w_pulse) begin
        r_event <= 1'b1;
        r_type  <= (r_state == RISE);
      end else if (clear_i) begin
        r_event <= 1'b0;
      end
    end
  end

  assign pulse_o     = w_pulse;
  assign event_o     = r_event;
  assign edge_type_o = r_type;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel dual-edge detector: independent channels plus an any-pulse summary.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_CH-1:0]   signal_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   clear_i,
  output logic [NUM_CH-1:0]   pulse_o,
  output logic [NUM_CH-1:0]   event_o,
  output logic [NUM_CH-1:0]   edge_type_o,
  output logic                any_pulse_o
);

  logic [NUM_CH-1:0] w_pulse;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .signal_i    (signal_i[c]),
      .mode_i      (mode_i[2*c +: 2]),
      .clear_i     (clear_i[c]),
      .pulse_o     (w_pulse[c]),
      .event_o     (event_o[c]),
      .edge_type_o (edge_type_o[c])
    );
  end

  assign pulse_o     = w_pulse;
  assign any_pulse_o = |w_pulse;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: three configurations observed as one 6-bit pulse vector.
module tb_multi_edge_detector;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: 4 channels, 2 sync stages, init level 0
  logic [3:0] sig, clr, p, ev, et;
  logic [7:0] mode;
  logic       any;
  // Unsynchronised single channel
  logic       sig0, clr0, p0, ev0, et0, any0;
  logic [1:0] mode0;
  // Init-level-1 single channel
  logic       sig1, clr1, p1, ev1, et1, any1;
  logic [1:0] mode1;

  multi_edge_detector #(.NUM_CH(4), .SYNC_STAGES(2), .INIT_LEVEL(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig), .mode_i(mode), .clear_i(clr),
    .pulse_o(p), .event_o(ev), .edge_type_o(et), .any_pulse_o(any));

  multi_edge_detector #(.NUM_CH(1), .SYNC_STAGES(0), .INIT_LEVEL(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig0), .mode_i(mode0), .clear_i(clr0),
    .pulse_o(p0), .event_o(ev0), .edge_type_o(et0), .any_pulse_o(any0));

  multi_edge_detector #(.NUM_CH(1), .SYNC_STAGES(2), .INIT_LEVEL(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig1), .mode_i(mode1), .clear_i(clr1),
    .pulse_o(p1), .event_o(ev1), .edge_type_o(et1), .any_pulse_o(any1));

  logic [5:0] obs;
  assign obs = {p1, p0, p};

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt1 = 0;
  int   cnt2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected pulse vector for the negedge sampled while cyc == c; same-cycle entries merge.
  task automatic push(input int c, input logic [5:0] v);
    exp_t e;
    if (q.size() > 0 && q[q.size()-1].cyc == c) begin
      e = q.pop_back();
      e.vec = e.vec | v;
    end else begin
      e.cyc = c;
      e.vec = v;
    end
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_pulse: cycle %0d got none required %b", e.cyc, e.vec);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          chk("pulse_vec", {26'd0, obs}, {26'd0, e.vec});
          chk("any_pulse", {31'd0, any}, {31'd0, (e.vec[3:0] != 4'd0)});
        end else if (obs != 6'd0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: cycle %0d got %b required 000000", cyc, obs);
        end
        if (p[1]) cnt1++;
        if (p[2]) cnt2++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sig   = 4'b0000;  clr  = 4'b0000;
    mode  = 8'b00_10_01_11;           // ch3 off, ch2 fall, ch1 rise, ch0 both
    sig0  = 1'b0;     clr0 = 1'b0;  mode0 = 2'b11;
    sig1  = 1'b1;     clr1 = 1'b0;  mode1 = 2'b11;
    fork
      monitor();
    join_none

    // Reset state
    cycles(3);
    chk("rst_pulse", {26'd0, obs}, 32'd0);
    chk("rst_event", {28'd0, ev}, 32'd0);
    chk("rst_type",  {28'd0, et}, 32'd0);
    chk("rst_any",   {31'd0, any}, 32'd0);
    chk("rst_ev1",   {31'd0, ev1}, 32'd0);
    rst_n = 1'b1;
    cycles(4);

    // Test 1: ch0 rise then fall, latency SYNC_STAGES+1 edges
    push(cyc + 3, 6'b000001);
    sig[0] = 1'b1;
    cycles(3);
    chk("t1_event_not_yet", {31'd0, ev[0]}, 32'd0);
    cycles(1);
    chk("t1_event_set", {31'd0, ev[0]}, 32'd1);
    chk("t1_type_rise", {31'd0, et[0]}, 32'd1);
    push(cyc + 3, 6'b000001);
    sig[0] = 1'b0;
    cycles(4);
    chk("t1_type_fall", {31'd0, et[0]}, 32'd0);
    chk("t1_event_held", {31'd0, ev[0]}, 32'd1);

    // Test 2: mode filtering, period-8 square wave on ch1..ch3
    cnt1 = 0;
    cnt2 = 0;
    for (int i = 0; i < 3; i++) begin
      push(cyc + 3, 6'b000010);
      sig[3:1] = 3'b111;
      cycles(4);
      push(cyc + 3, 6'b000100);
      sig[3:1] = 3'b000;
      cycles(4);
    end
    cycles(24);
    chk("t2_rise_count", cnt1, 32'd3);
    chk("t2_fall_count", cnt2, 32'd3);
    chk("t2_events", {28'd0, ev}, 32'h7);
    chk("t2_types",  {28'd0, et[3:1]}, 32'h1);

    // Test 3: unsynchronised channel toggling every cycle
    for (int i = 0; i < 6; i++) begin
      push(cyc + 1, 6'b010000);
      sig0 = ~sig0;
      cycles(1);
    end
    cycles(3);
    chk("t3_type_last_fall", {31'd0, et0}, 32'd0);
    chk("t3_event", {31'd0, ev0}, 32'd1);

    // Test 4: clear racing with set, then clear in a quiet cycle
    clr[0] = 1'b1;
    cycles(1);
    clr[0] = 1'b0;
    chk("t4_pre_clear", {31'd0, ev[0]}, 32'd0);
    push(cyc + 3, 6'b000001);
    sig[0] = 1'b1;
    cycles(3);
    clr[0] = 1'b1;
    cycles(1);
    clr[0] = 1'b0;
    chk("t4_set_wins", {31'd0, ev[0]}, 32'd1);
    cycles(2);
    clr[0] = 1'b1;
    cycles(1);
    clr[0] = 1'b0;
    chk("t4_quiet_clear", {31'd0, ev[0]}, 32'd0);

    // Test 5: INIT_LEVEL=1 held high through reset gives nothing; first fall pulses
    chk("t5_no_event", {31'd0, ev1}, 32'd0);
    push(cyc + 3, 6'b100000);
    sig1 = 1'b0;
    cycles(4);
    chk("t5_type_fall", {31'd0, et1}, 32'd0);
    chk("t5_event", {31'd0, ev1}, 32'd1);

    // Test 6: asynchronous reset in the middle of a pulse
    cycles(2);
    push(cyc + 3, 6'b000001);
    sig[0] = 1'b0;
    cycles(3);
    #1;
    chk("t6_pulse_before", {31'd0, p[0]}, 32'd1);
    rst_n = 1'b0;
    sig1  = 1'b1;
    #1;
    chk("t6_pulse_killed", {28'd0, p}, 32'd0);
    chk("t6_event_killed", {28'd0, ev}, 32'd0);
    chk("t6_type_killed",  {28'd0, et}, 32'd0);
    chk("t6_any_killed",   {31'd0, any}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(10);
    chk("t6_no_spurious_event", {25'd0, ev1, ev0, ev}, 32'd0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
